comp_req_sequencer: RTL and testbench

Request front-end that sits directly upstream of the compression/decompression engine on the `comp_if` bus. It buffers compress/decompress requests from the testbench-side producer in a small FIFO and issues them to the engine one at a time. It waits for each engine response, or a timeout, and returns a result record to the consumer through a valid/ready handshake. It guarantees that at most one operation is outstanding at the engine.

---
 rtl/comp_req_sequencer_pkg.sv | 44 ++++
 rtl/comp_req_sequencer_if.sv | 40 ++++
 rtl/comp_req_sequencer_fifo.sv | 43 ++++
 rtl/comp_req_sequencer.sv | 131 +++++++++++++
 tb/tb_comp_req_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/comp_req_sequencer_pkg.sv
// Shared types and constants for the compression-engine request sequencer.
package comp_pkg;

   localparam int PLAIN_W = 80;
   localparam int CODE_W  = 8;

   typedef enum logic [1:0] {
      CMD_NOP        = 2'b00,
      CMD_COMPRESS   = 2'b01,
      CMD_DECOMPRESS = 2'b10
   } cmd_e;

   typedef enum logic [1:0] {
      RESP_NONE = 2'b00,
      RESP_OK   = 2'b01,
      RESP_FAIL = 2'b10,
      RESP_RSVD = 2'b11
   } resp_e;

   localparam logic [1:0] ST_NONE  = 2'b00;
   localparam logic [1:0] ST_OK    = 2'b01;
   localparam logic [1:0] ST_FAIL  = 2'b10;
   localparam logic [1:0] ST_ABORT = 2'b11;

   // Request record at the default code width; the sequencer packs its FIFO
   // entries in this same {cmd, data, code} order at its own DATA_WIDTH.
   typedef struct packed {
      logic [1:0]         cmd;
      logic [PLAIN_W-1:0] data;
      logic [CODE_W-1:0]  code;
   } req_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } seq_state_e;

   function automatic logic cmd_legal(input logic [1:0] c);
      return (c == CMD_COMPRESS) || (c == CMD_DECOMPRESS);
   endfunction

endpackage

// File: rtl/comp_req_sequencer_if.sv
// Producer, engine and consumer signals of the request sequencer.
// master = sequencer side, slave = producer/engine/consumer side.
interface comp_req_sequencer_if #(
   parameter int DATA_WIDTH = 8
);
   logic                        req_valid;
   logic                        req_ready;
   logic [1:0]                  req_cmd;
   logic [comp_pkg::PLAIN_W-1:0] req_data;
   logic [DATA_WIDTH-1:0]       req_code;

   logic [1:0]                  command;
   logic [comp_pkg::PLAIN_W-1:0] data_in;
   logic [DATA_WIDTH-1:0]       compressed_in;
   logic [1:0]                  response;
   logic [DATA_WIDTH-1:0]       compressed_out;
   logic [comp_pkg::PLAIN_W-1:0] decompressed_out;

   logic                        rsp_valid;
   logic                        rsp_ready;
   logic [1:0]                  rsp_status;
   logic [DATA_WIDTH-1:0]       rsp_code;
   logic [comp_pkg::PLAIN_W-1:0] rsp_data;

   modport master (
      input  req_valid, req_cmd, req_data, req_code,
      input  response, compressed_out, decompressed_out,
      input  rsp_ready,
      output req_ready, command, data_in, compressed_in,
      output rsp_valid, rsp_status, rsp_code, rsp_data
   );

   modport slave (
      output req_valid, req_cmd, req_data, req_code,
      output response, compressed_out, decompressed_out,
      output rsp_ready,
      input  req_ready, command, data_in, compressed_in,
      input  rsp_valid, rsp_status, rsp_code, rsp_data
   );
endinterface

// File: rtl/comp_req_sequencer_fifo.sv
// Request buffer: power-of-two depth, wrap-bit pointers, simultaneous push/pop.
module comp_req_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   // A pop frees the head slot in the same cycle, so a push is legal even when full.
   assign w_do_push = i_push && (!o_full || i_pop);
   assign w_do_pop  = i_pop && !o_empty;
   assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
   end
endmodule

// File: rtl/comp_req_sequencer.sv
// Request front-end for the compression engine: buffers requests, keeps at most
// one operation outstanding at the engine, and returns one result per request.
module comp_req_sequencer
   import comp_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 16
) (
   input logic                  clk,
   input logic                  reset,
   comp_req_sequencer_if.master bus
);
   localparam int ENT_W = 2 + PLAIN_W + DATA_WIDTH;
   localparam int CNT_W = $clog2(TIMEOUT) + 1;

   seq_state_e            r_state;
   seq_state_e            w_next;
   logic                  w_full, w_empty, w_push, w_pop;
   logic                  w_head_legal, w_got_rsp, w_timeout;
   logic [ENT_W-1:0]      w_wdata, w_head;
   logic [1:0]            w_head_cmd;
   logic [PLAIN_W-1:0]    w_head_data;
   logic [DATA_WIDTH-1:0] w_head_code;
   logic [1:0]            r_cmd;
   logic [PLAIN_W-1:0]    r_data_in;
   logic [DATA_WIDTH-1:0] r_comp_in;
   logic [CNT_W-1:0]      r_cnt;
   logic [1:0]            r_status;
   logic [DATA_WIDTH-1:0] r_rsp_code;
   logic [PLAIN_W-1:0]    r_rsp_data;
   logic [1:0]            w_command;
   logic                  w_rsp_valid;

   assign w_wdata = {bus.req_cmd, bus.req_data, bus.req_code};
   assign {w_head_cmd, w_head_data, w_head_code} = w_head;
   assign w_push       = bus.req_valid && !w_full;
   assign w_pop        = (r_state == S_IDLE) && !w_empty;
   assign w_head_legal = cmd_legal(w_head_cmd);
   assign w_got_rsp    = (r_state == S_WAIT) && (bus.response != RESP_NONE);
   assign w_timeout    = (r_state == S_WAIT) && (bus.response == RESP_NONE) &&
                         (r_cnt == CNT_W'(TIMEOUT - 1));

   comp_req_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_wdata (w_wdata),
      .i_pop   (w_pop),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (!w_empty) w_next = w_head_legal ? S_ISSUE : S_RESP;
         S_ISSUE: w_next = S_WAIT;
         S_WAIT:  if (w_got_rsp || w_timeout) w_next = S_RESP;
         S_RESP:  if (bus.rsp_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_command   = CMD_NOP;
      w_rsp_valid = 1'b0;
      case (r_state)
         S_ISSUE: w_command   = r_cmd;
         S_RESP:  w_rsp_valid = 1'b1;
         default: ;
      endcase
   end

   // Engine-side operands load only for legal commands, so the bus keeps the
   // last issued values while idle or while illegal requests drain.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cmd      <= CMD_NOP;
         r_data_in  <= '0;
         r_comp_in  <= '0;
         r_cnt      <= '0;
         r_status   <= ST_NONE;
         r_rsp_code <= '0;
         r_rsp_data <= '0;
      end else begin
         if (w_pop && w_head_legal) begin
            r_cmd     <= w_head_cmd;
            r_data_in <= w_head_data;
            r_comp_in <= w_head_code;
         end
         if (r_state == S_ISSUE)     r_cnt <= '0;
         else if (r_state == S_WAIT) r_cnt <= r_cnt + CNT_W'(1);

         if (w_pop && !w_head_legal) begin
            r_status   <= ST_ABORT;
            r_rsp_code <= '0;
            r_rsp_data <= '0;
         end else if (w_got_rsp) begin
            // Reserved engine code is reported as an engine failure.
            r_status   <= (bus.response == RESP_OK) ? ST_OK : ST_FAIL;
            r_rsp_code <= (bus.response == RESP_OK && r_cmd == CMD_COMPRESS) ?
                          bus.compressed_out : '0;
            r_rsp_data <= (bus.response == RESP_OK && r_cmd == CMD_DECOMPRESS) ?
                          bus.decompressed_out : '0;
         end else if (w_timeout) begin
            r_status   <= ST_ABORT;
            r_rsp_code <= '0;
            r_rsp_data <= '0;
         end
      end
   end

   assign bus.req_ready     = !w_full;
   assign bus.command       = w_command;
   assign bus.data_in       = r_data_in;
   assign bus.compressed_in = r_comp_in;
   assign bus.rsp_valid     = w_rsp_valid;
   assign bus.rsp_status    = r_status;
   assign bus.rsp_code      = r_rsp_code;
   assign bus.rsp_data      = r_rsp_data;
endmodule

// File: tb/tb_comp_req_sequencer.sv
// Scoreboard bench: driver plans each request's engine behaviour, a reference
// model predicts the result, an engine model and a result monitor check the DUT.
module tb_comp_req_sequencer;
   import comp_pkg::*;

   localparam int DW = 8;
   localparam int TO = 16;

   typedef struct {
      req_t            rq;
      int              k;       // WAIT cycle of the engine reply; >= TO means never
      logic [1:0]      resp;
      logic [DW-1:0]   cout;
      logic [79:0]     dout;
   } plan_t;

   typedef struct {
      logic [1:0]    st;
      logic [DW-1:0] code;
      logic [79:0]   data;
      bit            legal;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   comp_req_sequencer_if #(.DATA_WIDTH(DW)) bus ();

   comp_req_sequencer #(
      .DATA_WIDTH (DW),
      .FIFO_DEPTH (4),
      .TIMEOUT    (TO)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   plan_t plan_q[$];
   exp_t  exp_q[$];
   int    n_chk = 0;
   int    n_pass = 0;
   int    n_rsp = 0;
   bit    outstanding = 0;
   int    rr_mode = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
   endtask

   function automatic logic [79:0] rnd80();
      logic [95:0] t;
      t = {$urandom, $urandom, $urandom};
      return t[79:0];
   endfunction

   function automatic plan_t mk(input logic [1:0] c, input logic [79:0] d, input logic [DW-1:0] cd,
                                input int k, input logic [1:0] r, input logic [DW-1:0] co,
                                input logic [79:0] dout);
      plan_t p;
      p.rq.cmd = c; p.rq.data = d; p.rq.code = cd;
      p.k = k; p.resp = r; p.cout = co; p.dout = dout;
      return p;
   endfunction

   // Expected result straight from the result rules.
   function automatic exp_t model(input plan_t p);
      exp_t e;
      e.legal = (p.rq.cmd == 2'b01) || (p.rq.cmd == 2'b10);
      e.code  = '0;
      e.data  = '0;
      if (!e.legal || p.k >= TO) e.st = 2'b11;
      else if (p.resp == 2'b01) begin
         e.st = 2'b01;
         if (p.rq.cmd == 2'b01) e.code = p.cout;
         else                   e.data = p.dout;
      end else e.st = 2'b10;
      return e;
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Call only just after a rising edge; returns just after the accepting edge.
   task automatic enq(input plan_t p);
      int w;
      w = 0;
      bus.req_valid = 1'b1;
      bus.req_cmd   = p.rq.cmd;
      bus.req_data  = p.rq.data;
      bus.req_code  = p.rq.code;
      forever begin
         @(negedge clk);
         if (bus.req_ready) break;
         w++;
         if (w > 400) begin
            chk("enq_ready_bound", 0, 1);
            bus.req_valid = 1'b0;
            return;
         end
      end
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      exp_q.push_back(model(p));
      if ((p.rq.cmd == 2'b01) || (p.rq.cmd == 2'b10)) plan_q.push_back(p);
   endtask

   // Cycle n = n-th falling edge after the enqueue edge.
   task automatic measure(output int c_cmd, output int c_rsp, input int lim);
      c_cmd = -1;
      c_rsp = -1;
      for (int n = 1; n <= lim; n++) begin
         @(negedge clk);
         if (c_cmd < 0 && bus.command != 2'b00) c_cmd = n;
         if (bus.rsp_valid) begin
            c_rsp = n;
            break;
         end
      end
      if (c_rsp < 0) chk("rsp_wait_bound", 0, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int lim);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < lim) begin
         step(1);
         n++;
      end
      chk("drain", exp_q.size(), 0);
   endtask

   // Consumer ready: 0 = hold off, 1 = always, else random.
   initial begin
      bus.rsp_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rr_mode)
            0:       bus.rsp_ready = 1'b0;
            1:       bus.rsp_ready = 1'b1;
            default: bus.rsp_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // Engine model: replies on WAIT cycle k of each issued command.
   initial begin
      plan_t p;
      bus.response         = 2'b00;
      bus.compressed_out   = '0;
      bus.decompressed_out = '0;
      forever begin
         @(negedge clk);
         if (!reset && bus.command != 2'b00) begin
            chk("one_outstanding", outstanding, 0);
            outstanding = 1;
            if (plan_q.size() == 0) chk("unplanned_issue", bus.command, 0);
            else begin
               p = plan_q.pop_front();
               chk("issue_cmd", bus.command, p.rq.cmd);
               chk("issue_data", bus.data_in, p.rq.data);
               chk("issue_code", bus.compressed_in, p.rq.code);
               if (p.k < TO) begin
                  @(posedge clk);
                  repeat (p.k) @(posedge clk);
                  #1;
                  bus.response         = p.resp;
                  bus.compressed_out   = p.cout;
                  bus.decompressed_out = p.dout;
                  @(posedge clk);
                  #1;
                  bus.response         = 2'b00;
                  bus.compressed_out   = DW'($urandom);
                  bus.decompressed_out = rnd80();
               end
            end
         end
      end
   end

   // Result monitor: pops the scoreboard on each accepted result.
   initial begin
      exp_t          e;
      bit            hold;
      logic [89:0]   held;
      hold = 0;
      held = '0;
      forever begin
         @(negedge clk);
         if (reset || !bus.rsp_valid) hold = 0;
         else begin
            if (hold) chk("rsp_stable", {bus.rsp_status, bus.rsp_code, bus.rsp_data}, held);
            if (bus.rsp_ready) begin
               hold = 0;
               n_rsp++;
               if (exp_q.size() == 0) chk("unexpected_rsp", bus.rsp_status, 0);
               else begin
                  e = exp_q.pop_front();
                  chk("rsp_status", bus.rsp_status, e.st);
                  chk("rsp_code", bus.rsp_code, e.code);
                  chk("rsp_data", bus.rsp_data, e.data);
                  if (e.legal) outstanding = 0;
               end
            end else begin
               hold = 1;
               held = {bus.rsp_status, bus.rsp_code, bus.rsp_data};
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: run did not complete, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int    c_cmd, c_rsp, n0;
      plan_t p;
      reset         = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_cmd   = 2'b00;
      bus.req_data  = '0;
      bus.req_code  = '0;
      step(3);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_req_ready", bus.req_ready, 1);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_command", bus.command, 0);
      chk("rst_data_in", bus.data_in, 0);
      chk("rst_compressed_in", bus.compressed_in, 0);
      chk("rst_rsp_status", bus.rsp_status, 0);
      chk("rst_rsp_code", bus.rsp_code, 0);
      chk("rst_rsp_data", bus.rsp_data, 0);
      rr_mode = 1;
      step(2);

      // Compress, reply ok on WAIT cycle 2.
      enq(mk(2'b01, 80'h1234, 8'h3c, 2, 2'b01, 8'h05, rnd80()));
      measure(c_cmd, c_rsp, 40);
      chk("cmp_issue_cycle", c_cmd, 2);
      chk("cmp_rsp_cycle", c_rsp, 6);
      step(2);

      // Decompress, reply ok on WAIT cycle 1.
      enq(mk(2'b10, rnd80(), 8'h05, 1, 2'b01, 8'ha5, 80'h1234));
      measure(c_cmd, c_rsp, 40);
      chk("dec_rsp_cycle", c_rsp, 5);
      step(2);

      // Timeout, with a second request queued behind it.
      enq(mk(2'b01, rnd80(), 8'h77, 99, 2'b00, 8'h00, 80'h0));
      enq(mk(2'b01, 80'hbeef, 8'h12, 0, 2'b01, 8'h9a, rnd80()));
      measure(c_cmd, c_rsp, 60);
      chk("to_issue_cycle", c_cmd, 1);
      chk("to_rsp_cycle", c_rsp, 18);
      drain(100);

      // Illegal commands never touch the engine.
      enq(mk(2'b11, rnd80(), 8'h01, 0, 2'b01, 8'h00, 80'h0));
      measure(c_cmd, c_rsp, 20);
      chk("ill11_rsp_cycle", c_rsp, 2);
      chk("ill11_no_cmd", c_cmd, -1);
      enq(mk(2'b00, rnd80(), 8'h02, 0, 2'b01, 8'h00, 80'h0));
      measure(c_cmd, c_rsp, 20);
      chk("ill00_rsp_cycle", c_rsp, 2);
      chk("ill00_no_cmd", c_cmd, -1);
      step(2);

      // Five back-to-back requests against a slow engine fill the buffer.
      for (int i = 0; i < 5; i++)
         enq(mk(2'($urandom_range(1, 2)), rnd80(), DW'($urandom), 10,
                2'($urandom_range(1, 3)), DW'($urandom), rnd80()));
      @(negedge clk);
      chk("full_req_ready", bus.req_ready, 0);
      step(1);
      drain(400);

      // Reset while in WAIT with two entries buffered and the consumer stalled.
      rr_mode = 0;
      step(2);
      enq(mk(2'b01, rnd80(), 8'h11, 99, 2'b00, 8'h00, 80'h0));
      enq(mk(2'b10, rnd80(), 8'h22, 3, 2'b01, 8'h00, rnd80()));
      enq(mk(2'b01, rnd80(), 8'h33, 3, 2'b01, 8'h44, rnd80()));
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("mid_rst_rsp_valid", bus.rsp_valid, 0);
      chk("mid_rst_req_ready", bus.req_ready, 1);
      chk("mid_rst_command", bus.command, 0);
      exp_q.delete();
      plan_q.delete();
      outstanding = 0;
      @(posedge clk);
      #1;
      reset   = 1'b0;
      rr_mode = 1;
      n0 = n_rsp;
      step(40);
      chk("flush_no_rsp", n_rsp - n0, 0);

      // Randomized traffic with a random consumer.
      rr_mode = 2;
      for (int i = 0; i < 40; i++) begin
         p = mk(2'($urandom_range(1, 2)), rnd80(), DW'($urandom), $urandom_range(0, 19),
                2'($urandom_range(1, 3)), DW'($urandom), rnd80());
         if ($urandom_range(0, 9) == 0) p.rq.cmd = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
         enq(p);
         step($urandom_range(0, 3));
      end
      drain(3000);
      rr_mode = 1;
      step(2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
